// File: rtl/mips_defs_pkg.sv
// Shared MIPS-subset definitions for the execute operand stage: ALUctl codes,
// opcode/funct codes, widths, the ID/EX bubble constant and the instruction decoder.
package mips_defs_pkg;

  localparam int DATA_LEN = 32;
  localparam int ALUCTL_W = 4;
  localparam int REG_W    = 5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADDU = 4'b0010;
  localparam logic [3:0] ALU_ADDI = 4'b0011;
  localparam logic [3:0] ALU_SUBU = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1010;
  localparam logic [3:0] ALU_SLL  = 4'b1011;
  localparam logic [3:0] ALU_SRL  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    K_R_ALU     = 2'd0,
    K_SHIFT_IMM = 2'd1,
    K_SHIFT_VAR = 2'd2,
    K_I_TYPE    = 2'd3
  } op_kind_t;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [ALUCTL_W-1:0] aluctl;
    logic                regwrite;
    logic                memread;
    logic                memwrite;
  } ex_ctl_t;

  localparam ex_ctl_t EX_BUBBLE = '0;

  typedef struct packed {
    logic [ALUCTL_W-1:0] aluctl;
    logic                regwrite;
    logic                memread;
    logic                memwrite;
    logic                sign_ext;
    logic                is_rtype;
    op_kind_t            kind;
  } dec_t;

  // Unsupported encodings fall through with every control bit cleared.
  function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    dec_t d;
    d = '0;
    d.kind = K_R_ALU;
    if (opcode == OP_RTYPE) begin
      d.is_rtype = 1'b1;
      d.regwrite = 1'b1;
      case (funct)
        FN_AND:  d.aluctl = ALU_AND;
        FN_OR:   d.aluctl = ALU_OR;
        FN_ADDU: d.aluctl = ALU_ADDU;
        FN_SUBU: d.aluctl = ALU_SUBU;
        FN_SLT:  d.aluctl = ALU_SLT;
        FN_XOR:  d.aluctl = ALU_XOR;
        FN_NOR:  d.aluctl = ALU_NOR;
        FN_SLL:  begin d.aluctl = ALU_SLL; d.kind = K_SHIFT_IMM; end
        FN_SRL:  begin d.aluctl = ALU_SRL; d.kind = K_SHIFT_IMM; end
        FN_SRA:  begin d.aluctl = ALU_SRA; d.kind = K_SHIFT_IMM; end
        FN_SLLV: begin d.aluctl = ALU_SLL; d.kind = K_SHIFT_VAR; end
        FN_SRLV: begin d.aluctl = ALU_SRL; d.kind = K_SHIFT_VAR; end
        FN_SRAV: begin d.aluctl = ALU_SRA; d.kind = K_SHIFT_VAR; end
        default: d.regwrite = 1'b0;
      endcase
    end else begin
      d.kind = K_I_TYPE;
      case (opcode)
        OP_ADDI: begin d.aluctl = ALU_ADDI; d.regwrite = 1'b1; d.sign_ext = 1'b1; end
        OP_SLTI: begin d.aluctl = ALU_SLT;  d.regwrite = 1'b1; d.sign_ext = 1'b1; end
        OP_ANDI: begin d.aluctl = ALU_AND;  d.regwrite = 1'b1; end
        OP_ORI:  begin d.aluctl = ALU_OR;   d.regwrite = 1'b1; end
        OP_XORI: begin d.aluctl = ALU_XOR;  d.regwrite = 1'b1; end
        OP_LUI:  begin d.aluctl = ALU_LUI;  d.regwrite = 1'b1; end
        OP_LW: begin
          d.aluctl   = ALU_ADDU;
          d.regwrite = 1'b1;
          d.memread  = 1'b1;
          d.sign_ext = 1'b1;
        end
        OP_SW: begin
          d.aluctl   = ALU_ADDU;
          d.memwrite = 1'b1;
          d.sign_ext = 1'b1;
        end
        default: d.aluctl = ALU_AND;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/seg_execute_forward_unit.sv
// Forwarding-select generation for the rs and rt operands of the instruction in EX.
// EX/MEM wins over MEM/WB; register $0 always reads the latched value.
module seg_execute_forward_unit
  import mips_defs_pkg::*;
#(
  parameter int NB_REG = REG_W
) (
  input  logic [NB_REG-1:0] i_rs,
  input  logic [NB_REG-1:0] i_rt,
  input  logic              i_exmem_regwrite,
  input  logic [NB_REG-1:0] i_exmem_rd,
  input  logic              i_memwb_regwrite,
  input  logic [NB_REG-1:0] i_memwb_rd,
  output logic [1:0]        o_sel_rs,
  output logic [1:0]        o_sel_rt
);

  function automatic fwd_sel_t sel_for(input logic [NB_REG-1:0] r);
    fwd_sel_t s;
    s = FWD_REG;
    if (r != '0) begin
      if (i_exmem_regwrite && (i_exmem_rd == r)) s = FWD_EXMEM;
      else if (i_memwb_regwrite && (i_memwb_rd == r)) s = FWD_MEMWB;
    end
    return s;
  endfunction

  always_comb begin
    o_sel_rs = sel_for(i_rs);
    o_sel_rt = sel_for(i_rt);
  end

endmodule

// File: rtl/seg_execute_operand_stage.sv
// ID/EX pipeline register and ALU operand builder with load-use hazard detection.
// Optional macro SEG_EX_FORWARD_EN enables EX/MEM and MEM/WB operand forwarding.
module seg_execute_operand_stage
  import mips_defs_pkg::*;
#(
  parameter int LEN       = DATA_LEN,
  parameter int NB_ALUCTL = ALUCTL_W,
  parameter int NB_REG    = REG_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [5:0]           i_opcode,
  input  logic [5:0]           i_funct,
  input  logic [4:0]           i_shamt,
  input  logic [15:0]          i_imm,
  input  logic [NB_REG-1:0]    i_rs,
  input  logic [NB_REG-1:0]    i_rt,
  input  logic [NB_REG-1:0]    i_rd,
  input  logic [LEN-1:0]       i_rs_data,
  input  logic [LEN-1:0]       i_rt_data,
  input  logic                 i_exmem_regwrite,
  input  logic [NB_REG-1:0]    i_exmem_rd,
  input  logic [LEN-1:0]       i_exmem_data,
  input  logic                 i_memwb_regwrite,
  input  logic [NB_REG-1:0]    i_memwb_rd,
  input  logic [LEN-1:0]       i_memwb_data,
  output logic                 o_valid,
  output logic [NB_ALUCTL-1:0] o_ALUctl,
  output logic [LEN-1:0]       o_data_a,
  output logic [LEN-1:0]       o_data_b,
  output logic [LEN-1:0]       o_store_data,
  output logic [NB_REG-1:0]    o_write_reg,
  output logic                 o_regwrite,
  output logic                 o_memread,
  output logic                 o_memwrite,
  output logic                 o_hazard_stall
);

  ex_ctl_t           r_ctl;
  op_kind_t          r_kind;
  logic [NB_REG-1:0] r_rs;
  logic [NB_REG-1:0] r_rt;
  logic [NB_REG-1:0] r_write_reg;
  logic [4:0]        r_shamt;
  logic [LEN-1:0]    r_rs_data;
  logic [LEN-1:0]    r_rt_data;
  logic [LEN-1:0]    r_imm_ext;

  dec_t              w_dec;
  logic [LEN-1:0]    w_imm_ext;
  logic [1:0]        w_sel_rs;
  logic [1:0]        w_sel_rt;
  logic [LEN-1:0]    w_fwd_rs;
  logic [LEN-1:0]    w_fwd_rt;

  assign w_dec     = decode(i_opcode, i_funct);
  assign w_imm_ext = w_dec.sign_ext ? {{(LEN-16){i_imm[15]}}, i_imm}
                                    : {{(LEN-16){1'b0}}, i_imm};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ctl       <= EX_BUBBLE;
      r_kind      <= K_R_ALU;
      r_rs        <= '0;
      r_rt        <= '0;
      r_write_reg <= '0;
      r_shamt     <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm_ext   <= '0;
    end else if (i_flush || (!i_stall && !i_valid)) begin
      r_ctl       <= EX_BUBBLE;
      r_kind      <= K_R_ALU;
      r_rs        <= '0;
      r_rt        <= '0;
      r_write_reg <= '0;
      r_shamt     <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm_ext   <= '0;
    end else if (!i_stall) begin
      r_ctl.valid    <= 1'b1;
      r_ctl.aluctl   <= w_dec.aluctl;
      r_ctl.regwrite <= w_dec.regwrite;
      r_ctl.memread  <= w_dec.memread;
      r_ctl.memwrite <= w_dec.memwrite;
      r_kind         <= w_dec.kind;
      r_rs           <= i_rs;
      r_rt           <= i_rt;
      r_write_reg    <= w_dec.is_rtype ? i_rd : i_rt;
      r_shamt        <= i_shamt;
      r_rs_data      <= i_rs_data;
      r_rt_data      <= i_rt_data;
      r_imm_ext      <= w_imm_ext;
    end
  end

`ifdef SEG_EX_FORWARD_EN
  seg_execute_forward_unit #(
    .NB_REG (NB_REG)
  ) u_forward_unit (
    .i_rs             (r_rs),
    .i_rt             (r_rt),
    .i_exmem_regwrite (i_exmem_regwrite),
    .i_exmem_rd       (i_exmem_rd),
    .i_memwb_regwrite (i_memwb_regwrite),
    .i_memwb_rd       (i_memwb_rd),
    .o_sel_rs         (w_sel_rs),
    .o_sel_rt         (w_sel_rt)
  );

  // Load-use: the loaded value only exists after MEM, so forwarding cannot cover it.
  assign o_hazard_stall = r_ctl.memread && r_ctl.valid && (r_rt != '0) &&
                          ((r_rt == i_rs) || (r_rt == i_rt));
`else
  assign w_sel_rs = FWD_REG;
  assign w_sel_rt = FWD_REG;

  // Without forwarding any pending register write must drain before ID reads it.
  assign o_hazard_stall = r_ctl.valid && r_ctl.regwrite && (r_write_reg != '0) &&
                          ((r_write_reg == i_rs) || (r_write_reg == i_rt));

  logic w_unused_fwd;
  assign w_unused_fwd = ^{i_exmem_regwrite, i_exmem_rd, i_exmem_data,
                          i_memwb_regwrite, i_memwb_rd, i_memwb_data, r_rs, r_rt};
`endif

  always_comb begin
    w_fwd_rs = r_rs_data;
    w_fwd_rt = r_rt_data;
    case (w_sel_rs)
      FWD_EXMEM: w_fwd_rs = i_exmem_data;
      FWD_MEMWB: w_fwd_rs = i_memwb_data;
      default:   w_fwd_rs = r_rs_data;
    endcase
    case (w_sel_rt)
      FWD_EXMEM: w_fwd_rt = i_exmem_data;
      FWD_MEMWB: w_fwd_rt = i_memwb_data;
      default:   w_fwd_rt = r_rt_data;
    endcase
  end

  always_comb begin
    o_data_a = w_fwd_rs;
    o_data_b = w_fwd_rt;
    case (r_kind)
      K_SHIFT_IMM: begin
        o_data_a = w_fwd_rt;
        o_data_b = {{(LEN-5){1'b0}}, r_shamt};
      end
      K_SHIFT_VAR: begin
        o_data_a = w_fwd_rt;
        o_data_b = {{(LEN-5){1'b0}}, w_fwd_rs[4:0]};
      end
      K_I_TYPE: begin
        o_data_a = w_fwd_rs;
        o_data_b = r_imm_ext;
      end
      default: begin
        o_data_a = w_fwd_rs;
        o_data_b = w_fwd_rt;
      end
    endcase
  end

  assign o_valid      = r_ctl.valid;
  assign o_ALUctl     = r_ctl.aluctl;
  assign o_regwrite   = r_ctl.regwrite;
  assign o_memread    = r_ctl.memread;
  assign o_memwrite   = r_ctl.memwrite;
  assign o_write_reg  = r_write_reg;
  assign o_store_data = w_fwd_rt;

endmodule

// File: tb/tb_seg_execute_operand_stage.sv
// Directed bench for seg_execute_operand_stage; expectations follow SEG_EX_FORWARD_EN.
module tb_seg_execute_operand_stage;

`ifdef SEG_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst, i_stall, i_flush, i_valid;
  logic [5:0]  i_opcode, i_funct;
  logic [4:0]  i_shamt;
  logic [15:0] i_imm;
  logic [4:0]  i_rs, i_rt, i_rd;
  logic [31:0] i_rs_data, i_rt_data;
  logic        i_exmem_regwrite, i_memwb_regwrite;
  logic [4:0]  i_exmem_rd, i_memwb_rd;
  logic [31:0] i_exmem_data, i_memwb_data;
  logic        o_valid, o_regwrite, o_memread, o_memwrite, o_hazard_stall;
  logic [3:0]  o_ALUctl;
  logic [31:0] o_data_a, o_data_b, o_store_data;
  logic [4:0]  o_write_reg;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  seg_execute_operand_stage dut (
    .i_clk(clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
    .i_opcode(i_opcode), .i_funct(i_funct), .i_shamt(i_shamt), .i_imm(i_imm),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .i_exmem_regwrite(i_exmem_regwrite), .i_exmem_rd(i_exmem_rd), .i_exmem_data(i_exmem_data),
    .i_memwb_regwrite(i_memwb_regwrite), .i_memwb_rd(i_memwb_rd), .i_memwb_data(i_memwb_data),
    .o_valid(o_valid), .o_ALUctl(o_ALUctl), .o_data_a(o_data_a), .o_data_b(o_data_b),
    .o_store_data(o_store_data), .o_write_reg(o_write_reg), .o_regwrite(o_regwrite),
    .o_memread(o_memread), .o_memwrite(o_memwrite), .o_hazard_stall(o_hazard_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_r(input logic [5:0] funct, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] shamt,
                         input logic [31:0] rs_d, input logic [31:0] rt_d);
    i_valid = 1'b1; i_opcode = 6'h00; i_funct = funct; i_shamt = shamt;
    i_imm = {rd, shamt, funct};
    i_rs = rs; i_rt = rt; i_rd = rd; i_rs_data = rs_d; i_rt_data = rt_d;
  endtask

  task automatic drive_i(input logic [5:0] opcode, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [15:0] imm, input logic [31:0] rs_d, input logic [31:0] rt_d);
    i_valid = 1'b1; i_opcode = opcode; i_imm = imm;
    i_funct = imm[5:0]; i_shamt = imm[10:6]; i_rd = imm[15:11];
    i_rs = rs; i_rt = rt; i_rs_data = rs_d; i_rt_data = rt_d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
    i_exmem_regwrite = 1'b0; i_exmem_rd = 5'd0; i_exmem_data = 32'h0;
    i_memwb_regwrite = 1'b0; i_memwb_rd = 5'd0; i_memwb_data = 32'h0;
    drive_r(6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0000_1111, 32'h1111_0000);

    // reset holds everything at zero even with a valid ADDU presented
    tick();
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_aluctl", 32'(o_ALUctl), 32'h0);
    chk("rst_a", o_data_a, 32'h0);
    chk("rst_b", o_data_b, 32'h0);
    chk("rst_store", o_store_data, 32'h0);
    chk("rst_ctl", 32'({o_regwrite, o_memread, o_memwrite, o_hazard_stall}), 32'h0);
    chk("rst_wreg", 32'(o_write_reg), 32'h0);

    i_rst = 1'b0;
    tick();
    chk("addu_valid", 32'(o_valid), 32'h1);
    chk("addu_aluctl", 32'(o_ALUctl), 32'h2);
    chk("addu_a", o_data_a, 32'h0000_1111);
    chk("addu_b", o_data_b, 32'h1111_0000);
    chk("addu_regwrite", 32'(o_regwrite), 32'h1);
    chk("addu_wreg", 32'(o_write_reg), 32'd3);
    chk("addu_store", o_store_data, 32'h1111_0000);
    chk("addu_hazard", 32'(o_hazard_stall), 32'h0);

    // non-load producer: stall only without forwarding
    drive_r(6'h24, 5'd3, 5'd9, 5'd12, 5'd0, 32'h0, 32'h0);
    #1;
    chk("alu_dep_hazard", 32'(o_hazard_stall), FWD ? 32'h0 : 32'h1);

    drive_r(6'h03, 5'd0, 5'd4, 5'd6, 5'd2, 32'h0, 32'h1111_0000);
    tick();
    chk("sra_aluctl", 32'(o_ALUctl), 32'hD);
    chk("sra_a", o_data_a, 32'h1111_0000);
    chk("sra_b", o_data_b, 32'd2);
    chk("sra_wreg", 32'(o_write_reg), 32'd6);

    drive_r(6'h07, 5'd1, 5'd4, 5'd6, 5'd0, 32'h0000_0022, 32'h1111_0000);
    tick();
    chk("srav_aluctl", 32'(o_ALUctl), 32'hD);
    chk("srav_a", o_data_a, 32'h1111_0000);
    chk("srav_b", o_data_b, 32'd2);

    drive_i(6'h08, 5'd1, 5'd7, 16'hFFFE, 32'h0000_0010, 32'h0);
    tick();
    chk("addi_aluctl", 32'(o_ALUctl), 32'h3);
    chk("addi_a", o_data_a, 32'h0000_0010);
    chk("addi_b", o_data_b, 32'hFFFF_FFFE);
    chk("addi_wreg", 32'(o_write_reg), 32'd7);

    drive_i(6'h0D, 5'd1, 5'd7, 16'hFFFE, 32'h0000_0010, 32'h0);
    tick();
    chk("ori_aluctl", 32'(o_ALUctl), 32'h1);
    chk("ori_b", o_data_b, 32'h0000_FFFE);

    drive_i(6'h0F, 5'd0, 5'd8, 16'h8001, 32'h0, 32'h0);
    tick();
    chk("lui_aluctl", 32'(o_ALUctl), 32'h8);
    chk("lui_b", o_data_b, 32'h0000_8001);

    // forwarding priority on rs
    drive_r(6'h21, 5'd3, 5'd9, 5'd10, 5'd0, 32'h0000_1234, 32'h0000_0055);
    tick();
    i_exmem_regwrite = 1'b1; i_exmem_rd = 5'd3; i_exmem_data = 32'h0000_AAAA;
    i_memwb_regwrite = 1'b1; i_memwb_rd = 5'd3; i_memwb_data = 32'h0000_BBBB;
    #1;
    chk("fwd_exmem_a", o_data_a, FWD ? 32'h0000_AAAA : 32'h0000_1234);
    chk("fwd_exmem_b", o_data_b, 32'h0000_0055);
    i_exmem_regwrite = 1'b0;
    #1;
    chk("fwd_memwb_a", o_data_a, FWD ? 32'h0000_BBBB : 32'h0000_1234);
    i_memwb_rd = 5'd9;
    #1;
    chk("fwd_memwb_rt", o_store_data, FWD ? 32'h0000_BBBB : 32'h0000_0055);
    drive_r(6'h21, 5'd0, 5'd9, 5'd10, 5'd0, 32'h0000_0077, 32'h0000_0055);
    tick();
    i_exmem_regwrite = 1'b1; i_exmem_rd = 5'd0; i_memwb_rd = 5'd0;
    #1;
    chk("fwd_r0_a", o_data_a, 32'h0000_0077);
    i_exmem_regwrite = 1'b0; i_memwb_regwrite = 1'b0;

    // load-use hazard, then stall hold, then flush beating stall
    drive_i(6'h23, 5'd1, 5'd5, 16'h0004, 32'h0000_0100, 32'h0);
    tick();
    drive_r(6'h21, 5'd5, 5'd8, 5'd11, 5'd0, 32'h1, 32'h2);
    #1;
    chk("lw_hazard", 32'(o_hazard_stall), 32'h1);
    chk("lw_memread", 32'(o_memread), 32'h1);
    chk("lw_b", o_data_b, 32'h0000_0004);
    chk("lw_wreg", 32'(o_write_reg), 32'd5);
    i_stall = 1'b1;
    tick();
    chk("stall_memread", 32'(o_memread), 32'h1);
    chk("stall_wreg", 32'(o_write_reg), 32'd5);
    chk("stall_a", o_data_a, 32'h0000_0100);
    i_flush = 1'b1;
    tick();
    chk("flush_valid", 32'(o_valid), 32'h0);
    chk("flush_regwrite", 32'(o_regwrite), 32'h0);
    chk("flush_aluctl", 32'(o_ALUctl), 32'h0);
    chk("flush_hazard", 32'(o_hazard_stall), 32'h0);
    i_flush = 1'b0; i_stall = 1'b0;

    // rt = $0 never raises a hazard
    drive_i(6'h23, 5'd1, 5'd0, 16'h0008, 32'h0, 32'h0);
    tick();
    drive_r(6'h21, 5'd0, 5'd0, 5'd11, 5'd0, 32'h0, 32'h0);
    #1;
    chk("lw_r0_hazard", 32'(o_hazard_stall), 32'h0);

    drive_i(6'h2B, 5'd2, 5'd6, 16'hFFFC, 32'h0000_0200, 32'hDEAD_BEEF);
    tick();
    chk("sw_ctl", 32'({o_regwrite, o_memread, o_memwrite}), 32'h1);
    chk("sw_b", o_data_b, 32'hFFFF_FFFC);
    chk("sw_store", o_store_data, 32'hDEAD_BEEF);

    drive_i(6'h3F, 5'd1, 5'd2, 16'h0000, 32'h0, 32'h0);
    tick();
    chk("unsup_valid", 32'(o_valid), 32'h1);
    chk("unsup_ctl", 32'({o_ALUctl, o_regwrite, o_memread, o_memwrite}), 32'h0);
    drive_r(6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0, 32'h0);
    tick();
    chk("unsup_fn_valid", 32'(o_valid), 32'h1);
    chk("unsup_fn_ctl", 32'({o_ALUctl, o_regwrite}), 32'h0);

    drive_r(6'h21, 5'd1, 5'd2, 5'd3, 5'd0, 32'h5, 32'h6);
    i_valid = 1'b0;
    tick();
    chk("invalid_bubble", 32'({o_valid, o_regwrite}), 32'h0);

    // async reset mid-stall clears immediately; capture resumes after release
    i_valid = 1'b1;
    tick();
    i_stall = 1'b1;
    #2;
    i_rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(o_valid), 32'h0);
    chk("rst_async_a", o_data_a, 32'h0);
    tick();
    i_rst = 1'b0; i_stall = 1'b0;
    drive_r(6'h23, 5'd4, 5'd5, 5'd6, 5'd0, 32'h0000_0009, 32'h0000_0003);
    tick();
    chk("post_rst_aluctl", 32'(o_ALUctl), 32'h6);
    chk("post_rst_a", o_data_a, 32'h0000_0009);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
